// File: rtl/register_file.sv
// register_file: 32 x 32-bit general-purpose register file for the processor datapath.
// Two combinational read ports feed the ALU operands; one synchronous write port
// takes the writeback result. Every entry, including index 0, is ordinary storage.
module register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] r1,
    input  logic [ADDR_W-1:0] r2,
    input  logic [ADDR_W-1:0] w,
    input  logic [DATA_W-1:0] wD,
    input  logic              Control,
    output logic [DATA_W-1:0] rD1,
    output logic [DATA_W-1:0] rD2
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Storage: async clear of every entry while rst_n is low, otherwise a gated write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (Control) begin
            regs[w] <= wD;
        end
    end

    // Read ports have no write-through bypass: a same-cycle write shows up after the edge.
    assign rD1 = regs[r1];
    assign rD2 = regs[r2];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized
// read/write run compared against a plain array model of the 32 registers.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  w;
    logic [31:0] wD;
    logic        Control;
    logic [31:0] rD1;
    logic [31:0] rD2;

    logic [31:0] model [32];
    int total;
    int bad;

    register_file dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .r1      (r1),
        .r2      (r2),
        .w       (w),
        .wD      (wD),
        .Control (Control),
        .rD1     (rD1),
        .rD2     (rD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Write one entry through the port, applying the same update to the model.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        w = a; wD = d; Control = 1'b1;
        @(posedge clk);
        model[a] = d;
        #1;
        Control = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Control = 1'b0; w = '0; wD = '0; r1 = 5'd0; r2 = 5'd1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold_rD1", rD1, 32'h0);
        chk("reset_hold_rD2", rD2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            r1 = 5'(i); r2 = 5'(31 - i);
            #1;
            chk("reset_clear_rD1", rD1, 32'h0);
            chk("reset_clear_rD2", rD2, 32'h0);
        end
    endtask

    task automatic test_basic_write();
        do_write(5'd0, 32'hFFFF_FFFF);
        r1 = 5'd0; r2 = 5'd1;
        #1;
        chk("w0_rD1", rD1, 32'hFFFF_FFFF);
        chk("w0_rD2", rD2, 32'h0);
    endtask

    task automatic test_no_write();
        @(negedge clk);
        Control = 1'b0; wD = 32'hF0F0_F0F0; r1 = 5'd0; r2 = 5'd1;
        for (int i = 0; i < 6; i++) begin
            w = 5'($urandom_range(0, 31));
            wD = $urandom;
            @(posedge clk); #1;
            chk("nowrite_rD1", rD1, 32'hFFFF_FFFF);
            chk("nowrite_rD2", rD2, model[1]);
        end
    endtask

    task automatic test_read_before_after();
        @(negedge clk);
        Control = 1'b1; w = 5'd1; wD = 32'hF0F0_F0F0; r1 = 5'd1; r2 = 5'd1;
        #1;
        chk("before_edge_rD1", rD1, 32'h0);
        chk("before_edge_rD2", rD2, 32'h0);
        @(posedge clk);
        model[1] = 32'hF0F0_F0F0;
        #1;
        Control = 1'b0;
        chk("after_edge_rD1", rD1, 32'hF0F0_F0F0);
        chk("after_edge_rD2", rD2, 32'hF0F0_F0F0);
        r1 = 5'd1; r2 = 5'd0;
        #1;
        chk("swap_rD1", rD1, 32'hF0F0_F0F0);
        chk("swap_rD2", rD2, 32'hFFFF_FFFF);
    endtask

    task automatic test_all_regs();
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i) * 32'h0101_0101);
        for (int i = 0; i < 32; i++) begin
            r1 = 5'(i); r2 = 5'(i);
            #1;
            chk("all_rD1", rD1, 32'(i) * 32'h0101_0101);
            chk("all_rD2", rD2, 32'(i) * 32'h0101_0101);
        end
        r1 = 5'd31; r2 = 5'd0;
        #1;
        chk("top_rD1", rD1, 32'h1F1F_1F1F);
        chk("bottom_rD2", rD2, 32'h0);
    endtask

    // Random traffic: check old values before each edge and updated values after it.
    task automatic test_random();
        logic        en;
        logic [4:0]  a;
        logic [31:0] d;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            en = 1'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            Control = en; w = a; wD = d;
            r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            #1;
            chk("rand_pre_rD1", rD1, model[r1]);
            chk("rand_pre_rD2", rD2, model[r2]);
            @(posedge clk);
            if (en) model[a] = d;
            #1;
            chk("rand_post_rD1", rD1, model[r1]);
            chk("rand_post_rD2", rD2, model[r2]);
        end
        Control = 1'b0;
    endtask

    task automatic test_async_reset();
        do_write(5'd7, 32'hDEAD_BEEF);
        do_write(5'd31, 32'h1234_5678);
        @(negedge clk);
        r1 = 5'd7; r2 = 5'd31;
        #2;
        chk("pre_areset_rD1", rD1, 32'hDEAD_BEEF);
        chk("pre_areset_rD2", rD2, 32'h1234_5678);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("areset_rD1", rD1, 32'h0);
        chk("areset_rD2", rD2, 32'h0);
        Control = 1'b1; w = 5'd7; wD = 32'hAAAA_5555;
        @(posedge clk); #1;
        chk("areset_blocked_write", rD1, 32'h0);
        @(negedge clk);
        Control = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("released_rD1", rD1, 32'h0);
        chk("released_rD2", rD2, 32'h0);
        do_write(5'd7, 32'h0BAD_F00D);
        #1;
        chk("post_release_write", rD1, 32'h0BAD_F00D);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_write();
        test_no_write();
        test_read_before_after();
        test_all_regs();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
